// File: rtl/line_mem_pkg.sv
// Shared types and helpers for the line-addressed data memory model.
// Holds the FSM state encoding and the byte-address to line-index mapping.
package line_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StAck
    } mem_state_e;

    localparam int unsigned LINE_OFFSET_BITS = 5;
    localparam int unsigned MAX_ADDR_BITS    = 64;

    // Drops the 32-byte line offset and wraps modulo depth (depth is a power of two).
    function automatic int unsigned line_index(input logic [MAX_ADDR_BITS-1:0] addr,
                                               input int unsigned depth);
        logic [MAX_ADDR_BITS-1:0] mask;
        mask = MAX_ADDR_BITS'(depth - 32'd1);
        return 32'((addr >> LINE_OFFSET_BITS) & mask);
    endfunction

endpackage

// File: rtl/line_data_memory_if.sv
// Request/response bundle between the data cache memory port and the line memory.
// Signal names are seen from the memory side.
interface line_data_memory_if #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned ADDR_BITS = 32
);
    logic                 enable_i;
    logic                 write_i;
    logic [ADDR_BITS-1:0] addr_i;
    logic [LINE_BITS-1:0] data_i;
    logic [LINE_BITS-1:0] data_o;
    logic                 ack_o;
    logic                 busy_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  data_o, ack_o, busy_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output data_o, ack_o, busy_o
    );
endinterface

// File: rtl/line_ram_array.sv
// Single-port line storage: synchronous write, combinational read, no reset.
// Contents survive reset of the surrounding controller.
module line_ram_array #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned DEPTH     = 512
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [LINE_BITS-1:0]     wdata_i,
    output logic [LINE_BITS-1:0]     rdata_o
);

    logic [LINE_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/line_data_memory.sv
// Off-chip line memory model: one 256-bit line read or write per request,
// completing with a one-cycle ack a fixed number of edges after acceptance.
module line_data_memory
    import line_mem_pkg::*;
#(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned LATENCY   = 10,
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    line_data_memory_if.slave   bus
);

    localparam int unsigned IdxBits = $clog2(DEPTH);
    localparam int unsigned CntBits = $clog2(LATENCY + 1);
    localparam logic [CntBits-1:0] CntLast = CntBits'(LATENCY);

    mem_state_e           state_q, state_d;
    logic [CntBits-1:0]   cnt_q, cnt_d;
    logic [IdxBits-1:0]   idx_q;
    logic                 write_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic [LINE_BITS-1:0] rdata_q;

    logic                 latch_req;
    logic                 access;
    logic [IdxBits-1:0]   req_idx;
    logic [IdxBits-1:0]   ram_idx;
    logic [LINE_BITS-1:0] ram_wdata;
    logic [LINE_BITS-1:0] ram_rdata;
    logic                 acc_write;
    logic                 ram_we;

    assign req_idx = IdxBits'(line_index(MAX_ADDR_BITS'(bus.addr_i), DEPTH));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_req = 1'b0;
        access    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.enable_i) begin
                    latch_req = 1'b1;
                    cnt_d     = CntBits'(1);
                    // With a single-edge latency the access happens on the accepting edge.
                    if (LATENCY == 1) begin
                        state_d = StAck;
                        access  = 1'b1;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == CntLast) begin
                    state_d = StAck;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Only the LATENCY==1 path accesses from StIdle, straight from the request inputs.
    assign ram_idx   = (state_q == StIdle) ? req_idx     : idx_q;
    assign ram_wdata = (state_q == StIdle) ? bus.data_i  : wdata_q;
    assign acc_write = (state_q == StIdle) ? bus.write_i : write_q;
    // Gate with reset so a request held during reset never reaches the array.
    assign ram_we    = access & acc_write & rst_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_req) begin
                idx_q   <= req_idx;
                write_q <= bus.write_i;
                wdata_q <= bus.data_i;
            end
            if (access && !acc_write) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    line_ram_array #(
        .LINE_BITS (LINE_BITS),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .idx_i   (ram_idx),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus.data_o = rdata_q;
    assign bus.ack_o  = (state_q == StAck);
    assign bus.busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_line_data_memory.sv
// Directed bench for line_data_memory: a LATENCY=10 instance for the main
// scenarios and a LATENCY=1 instance for the short-latency path.
module tb_line_data_memory;

    localparam int unsigned LineBits = 256;
    localparam int unsigned Depth    = 512;
    localparam int unsigned AddrBits = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [LineBits-1:0] pat_a5;
    logic [LineBits-1:0] pat3;
    logic [LineBits-1:0] pat7;
    logic [LineBits-1:0] pat4;
    logic [LineBits-1:0] pat_ff;
    logic [LineBits-1:0] pat_one;
    logic [LineBits-1:0] pat_dead;
    logic [LineBits-1:0] pat_l1;

    line_data_memory_if #(.LINE_BITS(LineBits), .ADDR_BITS(AddrBits)) bus ();
    line_data_memory_if #(.LINE_BITS(LineBits), .ADDR_BITS(AddrBits)) bus1 ();

    line_data_memory #(
        .LINE_BITS (LineBits),
        .DEPTH     (Depth),
        .LATENCY   (10),
        .ADDR_BITS (AddrBits)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    line_data_memory #(
        .LINE_BITS (LineBits),
        .DEPTH     (Depth),
        .LATENCY   (1),
        .ADDR_BITS (AddrBits)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by 200000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [AddrBits-1:0] a,
                         input logic [LineBits-1:0] d);
        bus.enable_i = 1'b1;
        bus.write_i  = w;
        bus.addr_i   = a;
        bus.data_i   = d;
        step();
        bus.enable_i = 1'b0;
    endtask

    task automatic wait_ack(input int limit, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < limit) begin
            step();
            cycles++;
            if (bus.ack_o === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic write_line(input logic [AddrBits-1:0] a, input logic [LineBits-1:0] d);
        int c;
        bit seen;
        issue(1'b1, a, d);
        wait_ack(20, c, seen);
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL preload_ack addr %h: ack seen %b expected 1", a, seen);
        end
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (bus.ack_o !== 1'b0) begin
            errors++; $display("FAIL reset_ack: got %b expected 0", bus.ack_o);
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
        end
        checks++;
        if (bus.data_o !== '0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", bus.data_o);
        end
        checks++;
        if (bus1.ack_o !== 1'b0 || bus1.busy_o !== 1'b0 || bus1.data_o !== '0) begin
            errors++;
            $display("FAIL reset_l1: ack %b busy %b data %h expected all 0",
                     bus1.ack_o, bus1.busy_o, bus1.data_o);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_write();
        logic exp_ack;
        logic exp_busy;
        issue(1'b1, 32'h0000_0040, pat_a5);
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) step();
            exp_ack  = (k == 10);
            exp_busy = (k <= 10);
            checks++;
            if (bus.ack_o !== exp_ack) begin
                errors++;
                $display("FAIL write_ack_timing cycle %0d: got %b expected %b",
                         k, bus.ack_o, exp_ack);
            end
            checks++;
            if (bus.busy_o !== exp_busy) begin
                errors++;
                $display("FAIL write_busy_timing cycle %0d: got %b expected %b",
                         k, bus.busy_o, exp_busy);
            end
        end
        checks++;
        if (bus.data_o !== '0) begin
            errors++; $display("FAIL write_keeps_data: got %h expected 0", bus.data_o);
        end
    endtask

    task automatic test_basic_read();
        int c;
        bit seen;
        issue(1'b0, 32'h0000_005F, '0);
        wait_ack(20, c, seen);
        checks++;
        if (!seen || c != 10) begin
            errors++; $display("FAIL read_latency: seen %b after %0d edges expected 10", seen, c);
        end
        checks++;
        if (bus.data_o !== pat_a5) begin
            errors++; $display("FAIL read_data: got %h expected %h", bus.data_o, pat_a5);
        end
        step();
        checks++;
        if (bus.ack_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL read_return_idle: ack %b busy %b expected 0 0", bus.ack_o, bus.busy_o);
        end
        checks++;
        if (bus.data_o !== pat_a5) begin
            errors++; $display("FAIL read_data_hold: got %h expected %h", bus.data_o, pat_a5);
        end
    endtask

    task automatic test_alias();
        int c;
        bit seen;
        write_line(32'h0000_4040, pat_one);
        issue(1'b0, 32'h0000_0040, '0);
        wait_ack(20, c, seen);
        checks++;
        if (!seen || bus.data_o !== pat_one) begin
            errors++;
            $display("FAIL alias_read: seen %b data %h expected %h", seen, bus.data_o, pat_one);
        end
        step();
    endtask

    task automatic test_ignored_inputs();
        int c;
        bit seen;
        int n_ack;
        write_line(32'h0000_0060, pat3);
        write_line(32'h0000_00E0, pat7);
        issue(1'b0, 32'h0000_0060, '0);
        for (int k = 1; k <= 8; k++) begin
            bus.enable_i = (k % 2 == 1);
            bus.write_i  = 1'b1;
            bus.addr_i   = 32'h0000_00E0;
            bus.data_i   = pat_dead;
            step();
            checks++;
            if (bus.ack_o !== 1'b0) begin
                errors++; $display("FAIL ignored_early_ack cycle %0d: got %b expected 0", k, bus.ack_o);
            end
        end
        bus.enable_i = 1'b0;
        bus.write_i  = 1'b0;
        wait_ack(10, c, seen);
        checks++;
        if (!seen || c != 2) begin
            errors++;
            $display("FAIL ignored_latency: seen %b after %0d more edges expected 2", seen, c);
        end
        checks++;
        if (bus.data_o !== pat3) begin
            errors++; $display("FAIL ignored_read_data: got %h expected %h", bus.data_o, pat3);
        end
        n_ack = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (bus.ack_o === 1'b1) n_ack++;
        end
        checks++;
        if (n_ack != 0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ignored_no_second_ack: acks %0d busy %b expected 0 0", n_ack, bus.busy_o);
        end
        issue(1'b0, 32'h0000_00E0, '0);
        wait_ack(20, c, seen);
        checks++;
        if (!seen || bus.data_o !== pat7) begin
            errors++;
            $display("FAIL ignored_line7_intact: seen %b data %h expected %h", seen, bus.data_o, pat7);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        int c;
        bit seen;
        int n_ack;
        write_line(32'h0000_0080, pat4);
        issue(1'b1, 32'h0000_0080, pat_ff);
        for (int k = 0; k < 4; k++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ack_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctrl: ack %b busy %b expected 0 0", bus.ack_o, bus.busy_o);
        end
        checks++;
        if (bus.data_o !== '0) begin
            errors++; $display("FAIL midreset_data: got %h expected 0", bus.data_o);
        end
        step();
        step();
        rst_n = 1'b1;
        n_ack = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.ack_o === 1'b1 || bus.busy_o === 1'b1) n_ack++;
        end
        checks++;
        if (n_ack != 0) begin
            errors++; $display("FAIL midreset_abandoned: %0d active cycles expected 0", n_ack);
        end
        issue(1'b0, 32'h0000_0080, '0);
        wait_ack(20, c, seen);
        checks++;
        if (!seen || bus.data_o !== pat4) begin
            errors++;
            $display("FAIL midreset_line4: seen %b data %h expected %h", seen, bus.data_o, pat4);
        end
        step();
    endtask

    task automatic test_held_enable();
        int n;
        int times [4];
        bit idle;
        n = 0;
        bus.enable_i = 1'b1;
        bus.write_i  = 1'b0;
        bus.addr_i   = 32'h0000_0040;
        for (int e = 1; e <= 40; e++) begin
            step();
            if (bus.ack_o === 1'b1) begin
                if (n < 4) times[n] = e;
                n++;
                checks++;
                if (bus.data_o !== pat_one) begin
                    errors++;
                    $display("FAIL held_data ack %0d: got %h expected %h", n, bus.data_o, pat_one);
                end
            end
        end
        bus.enable_i = 1'b0;
        idle = 1'b0;
        for (int k = 0; k < 15 && !idle; k++) begin
            step();
            if (bus.busy_o === 1'b0) idle = 1'b1;
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL held_ack_count: got %0d expected 3", n);
        end
        checks++;
        if (!idle) begin
            errors++; $display("FAIL held_drain: busy still %b expected 0", bus.busy_o);
        end
        if (n >= 3) begin
            checks++;
            if (times[0] != 11) begin
                errors++; $display("FAIL held_first_ack: edge %0d expected 11", times[0]);
            end
            checks++;
            if (times[1] - times[0] != 12 || times[2] - times[1] != 12) begin
                errors++;
                $display("FAIL held_spacing: got %0d and %0d expected 12 and 12",
                         times[1] - times[0], times[2] - times[1]);
            end
        end
    endtask

    task automatic test_latency1();
        bus1.enable_i = 1'b1;
        bus1.write_i  = 1'b1;
        bus1.addr_i   = 32'h0000_0100;
        bus1.data_i   = pat_l1;
        step();
        checks++;
        if (bus1.ack_o !== 1'b1 || bus1.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL l1_write_ack: ack %b busy %b expected 1 1", bus1.ack_o, bus1.busy_o);
        end
        checks++;
        if (bus1.data_o !== '0) begin
            errors++; $display("FAIL l1_write_keeps_data: got %h expected 0", bus1.data_o);
        end
        bus1.write_i = 1'b0;
        bus1.data_i  = '0;
        step();
        checks++;
        if (bus1.ack_o !== 1'b0 || bus1.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL l1_idle_after_ack: ack %b busy %b expected 0 0", bus1.ack_o, bus1.busy_o);
        end
        step();
        checks++;
        if (bus1.ack_o !== 1'b1) begin
            errors++; $display("FAIL l1_read_ack: got %b expected 1", bus1.ack_o);
        end
        checks++;
        if (bus1.data_o !== pat_l1) begin
            errors++; $display("FAIL l1_read_data: got %h expected %h", bus1.data_o, pat_l1);
        end
        bus1.enable_i = 1'b0;
        step();
        checks++;
        if (bus1.ack_o !== 1'b0 || bus1.data_o !== pat_l1) begin
            errors++;
            $display("FAIL l1_settle: ack %b data %h expected 0 %h", bus1.ack_o, bus1.data_o, pat_l1);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        pat_a5   = {32{8'hA5}};
        pat3     = {32{8'h33}};
        pat7     = {32{8'h77}};
        pat4     = {32{8'h44}};
        pat_ff   = 256'hFF;
        pat_one  = 256'h1;
        pat_dead = {8{32'hDEAD_BEEF}};
        pat_l1   = {8{32'h0123_4567}};
        bus.enable_i  = 1'b0;
        bus.write_i   = 1'b0;
        bus.addr_i    = '0;
        bus.data_i    = '0;
        bus1.enable_i = 1'b0;
        bus1.write_i  = 1'b0;
        bus1.addr_i   = '0;
        bus1.data_i   = '0;

        test_reset();
        test_basic_write();
        test_basic_read();
        test_alias();
        test_ignored_inputs();
        test_reset_mid_op();
        test_held_enable();
        test_latency1();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
